// File: rtl/serial_buffered_port_if.sv
// Serial-side and core-side valid/ready word streams of serial_buffered_port.
// slave = the adapter, master = the serial endpoints plus core driving it.
interface serial_buffered_port_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] ser_rx_data;
  logic                 ser_rx_valid;
  logic                 ser_rx_ready;
  logic                 ser_rts;
  logic [DATA_BITS-1:0] ser_tx_data;
  logic                 ser_tx_valid;
  logic                 ser_tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport slave (
    input  ser_rx_data, ser_rx_valid, ser_tx_ready, rx_ready, tx_data, tx_valid,
    output ser_rx_ready, ser_rts, ser_tx_data, ser_tx_valid, rx_data, rx_valid, tx_ready
  );

  modport master (
    output ser_rx_data, ser_rx_valid, ser_tx_ready, rx_ready, tx_data, tx_valid,
    input  ser_rx_ready, ser_rts, ser_tx_data, ser_tx_valid, rx_data, rx_valid, tx_ready
  );
endinterface

// File: rtl/serial_buffered_port.sv
// Serial endpoint adapter: RX/TX FIFOs (push at N, visible at N+1) and RTS from RX fill; ready drops only when full.
// SERIAL_BUFFERED_PORT_LEVEL_EN adds rx_level/tx_level registered fill outputs.
module serial_buffered_port #(
  parameter int DATA_BITS  = 8,
  parameter int RX_DEPTH   = 16,
  parameter int TX_DEPTH   = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef SERIAL_BUFFERED_PORT_LEVEL_EN
  output logic [$clog2(RX_DEPTH):0]  rx_level,
  output logic [$clog2(TX_DEPTH):0]  tx_level,
`endif
  serial_buffered_port_if.slave      bus
);

  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_PW + 1;
  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_PW + 1;
  localparam logic [RX_CW-1:0] RX_FULL   = RX_CW'(RX_DEPTH);
  localparam logic [RX_CW-1:0] RTS_LIMIT = RX_CW'(RX_DEPTH - RTS_MARGIN);
  localparam logic [TX_CW-1:0] TX_FULL   = TX_CW'(TX_DEPTH);

  logic                 r_init;
  logic                 r_rts;

  logic [DATA_BITS-1:0] r_rx_mem [RX_DEPTH];
  logic [RX_PW-1:0]     r_rx_wptr, r_rx_rptr;
  logic [RX_CW-1:0]     r_rx_count, w_rx_count_next;
  logic                 w_rx_push, w_rx_pop;

  logic [DATA_BITS-1:0] r_tx_mem [TX_DEPTH];
  logic [TX_PW-1:0]     r_tx_wptr, r_tx_rptr;
  logic [TX_CW-1:0]     r_tx_count, w_tx_count_next;
  logic                 w_tx_push, w_tx_pop;

  assign bus.ser_rx_ready = r_init & (r_rx_count != RX_FULL);
  assign bus.rx_valid     = (r_rx_count != '0);
  assign bus.rx_data      = r_rx_mem[r_rx_rptr];
  assign bus.ser_rts      = r_rts;

  assign bus.tx_ready     = r_init & (r_tx_count != TX_FULL);
  assign bus.ser_tx_valid = (r_tx_count != '0);
  assign bus.ser_tx_data  = r_tx_mem[r_tx_rptr];

  assign w_rx_push = bus.ser_rx_valid & bus.ser_rx_ready;
  assign w_rx_pop  = bus.rx_valid & bus.rx_ready;
  assign w_tx_push = bus.tx_valid & bus.tx_ready;
  assign w_tx_pop  = bus.ser_tx_valid & bus.ser_tx_ready;

  always_comb begin
    w_rx_count_next = r_rx_count;
    if (w_rx_push && !w_rx_pop) begin
      w_rx_count_next = r_rx_count + RX_CW'(1);
    end else if (!w_rx_push && w_rx_pop) begin
      w_rx_count_next = r_rx_count - RX_CW'(1);
    end
  end

  always_comb begin
    w_tx_count_next = r_tx_count;
    if (w_tx_push && !w_tx_pop) begin
      w_tx_count_next = r_tx_count + TX_CW'(1);
    end else if (!w_tx_push && w_tx_pop) begin
      w_tx_count_next = r_tx_count - TX_CW'(1);
    end
  end

  // init's next value is always 1, so rts rises on the same edge as the readies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init <= 1'b0;
      r_rts  <= 1'b0;
    end else begin
      r_init <= 1'b1;
      r_rts  <= (w_rx_count_next <= RTS_LIMIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
      for (int i = 0; i < RX_DEPTH; i++) r_rx_mem[i] <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wptr] <= bus.ser_rx_data;
        r_rx_wptr           <= r_rx_wptr + RX_PW'(1);
      end
      if (w_rx_pop) begin
        r_rx_rptr <= r_rx_rptr + RX_PW'(1);
      end
      r_rx_count <= w_rx_count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
      for (int i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wptr] <= bus.tx_data;
        r_tx_wptr           <= r_tx_wptr + TX_PW'(1);
      end
      if (w_tx_pop) begin
        r_tx_rptr <= r_tx_rptr + TX_PW'(1);
      end
      r_tx_count <= w_tx_count_next;
    end
  end

`ifdef SERIAL_BUFFERED_PORT_LEVEL_EN
  // the count registers already hold the post-edge fill level
  assign rx_level = r_rx_count;
  assign tx_level = r_tx_count;
`endif

endmodule

// File: tb/tb_serial_buffered_port.sv
// Directed bench for serial_buffered_port with default parameters (depths 16, margin 4).
module tb_serial_buffered_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serial_buffered_port_if #(.DATA_BITS(8)) bus ();

`ifdef SERIAL_BUFFERED_PORT_LEVEL_EN
  logic [4:0] rx_level;
  logic [4:0] tx_level;
`endif

  serial_buffered_port #(
    .DATA_BITS(8), .RX_DEPTH(16), .TX_DEPTH(16), .RTS_MARGIN(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SERIAL_BUFFERED_PORT_LEVEL_EN
    .rx_level (rx_level),
    .tx_level (tx_level),
`endif
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.ser_rx_data = '0; bus.ser_rx_valid = 1'b0; bus.ser_tx_ready = 1'b0;
    bus.rx_ready = 1'b0; bus.tx_data = '0; bus.tx_valid = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if ({bus.ser_rx_ready, bus.tx_ready, bus.ser_rts, bus.rx_valid, bus.ser_tx_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {bus.ser_rx_ready, bus.tx_ready, bus.ser_rts, bus.rx_valid, bus.ser_tx_valid});
    end
    rst_n = 1'b1;
    #1;
    total++;
    if ({bus.ser_rx_ready, bus.tx_ready, bus.ser_rts} !== 3'b000) begin
      bad++;
      $display("FAIL pre_init_ready got=%b exp=000", {bus.ser_rx_ready, bus.tx_ready, bus.ser_rts});
    end
    tick();
    total++;
    if ({bus.ser_rx_ready, bus.tx_ready, bus.ser_rts, bus.rx_valid, bus.ser_tx_valid} !== 5'b11100) begin
      bad++;
      $display("FAIL post_init got=%b exp=11100",
               {bus.ser_rx_ready, bus.tx_ready, bus.ser_rts, bus.rx_valid, bus.ser_tx_valid});
    end
  endtask

  task automatic test_rx_fill();
    logic exp_rts, exp_rdy;
    bus.rx_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      bus.ser_rx_data = 8'(i);
      bus.ser_rx_valid = 1'b1;
      tick();
      exp_rts = (i <= 12);
      exp_rdy = (i < 16);
      total++;
      if (bus.ser_rts !== exp_rts) begin
        bad++;
        $display("FAIL fill_rts word=%0d got=%b exp=%b", i, bus.ser_rts, exp_rts);
      end
      total++;
      if (bus.ser_rx_ready !== exp_rdy) begin
        bad++;
        $display("FAIL fill_ready word=%0d got=%b exp=%b", i, bus.ser_rx_ready, exp_rdy);
      end
    end
    bus.ser_rx_valid = 1'b0;
    bus.rx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      total++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'(i)) begin
        bad++;
        $display("FAIL drain_data idx=%0d got=%b/%h exp=1/%h", i, bus.rx_valid, bus.rx_data, 8'(i));
      end
      tick();
      exp_rts = ((16 - i) <= 12);
      total++;
      if (bus.ser_rts !== exp_rts) begin
        bad++;
        $display("FAIL drain_rts idx=%0d got=%b exp=%b", i, bus.ser_rts, exp_rts);
      end
    end
    bus.rx_ready = 1'b0;
    total++;
    if (bus.rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty got=%b exp=0", bus.rx_valid);
    end
  endtask

  task automatic test_tx_throughput();
    bus.ser_tx_ready = 1'b1;
    bus.tx_data = 8'hA5;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    total++;
    if (bus.ser_tx_valid !== 1'b1 || bus.ser_tx_data !== 8'hA5) begin
      bad++;
      $display("FAIL tx_first got=%b/%h exp=1/a5", bus.ser_tx_valid, bus.ser_tx_data);
    end
    tick();
    total++;
    if (bus.ser_tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL tx_popped got=%b exp=0", bus.ser_tx_valid);
    end
    for (int k = 0; k < 8; k++) begin
      bus.tx_data = 8'(8'h10 + k);
      bus.tx_valid = 1'b1;
      tick();
      total++;
      if (bus.ser_tx_valid !== 1'b1 || bus.ser_tx_data !== 8'(8'h10 + k) || bus.tx_ready !== 1'b1) begin
        bad++;
        $display("FAIL tx_stream k=%0d got=%b/%h/%b exp=1/%h/1", k, bus.ser_tx_valid,
                 bus.ser_tx_data, bus.tx_ready, 8'(8'h10 + k));
      end
    end
    bus.tx_valid = 1'b0;
    tick();
    bus.ser_tx_ready = 1'b0;
    total++;
    if (bus.ser_tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL tx_stream_end got=%b exp=0", bus.ser_tx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] w;
    bus.ser_tx_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.tx_data = 8'(8'h80 + k);
      bus.tx_valid = 1'b1;
      q.push_back(8'(8'h80 + k));
      tick();
    end
    for (int n = 0; n < 200; n++) begin
      w = 8'($urandom_range(0, 255));
      bus.tx_data = w;
      bus.tx_valid = 1'b1;
      bus.ser_tx_ready = 1'b1;
      total++;
      if (bus.ser_tx_valid !== 1'b1 || bus.ser_tx_data !== q[0]) begin
        bad++;
        $display("FAIL b2b_data n=%0d got=%b/%h exp=1/%h", n, bus.ser_tx_valid, bus.ser_tx_data, q[0]);
      end
      tick();
      void'(q.pop_front());
      q.push_back(w);
`ifdef SERIAL_BUFFERED_PORT_LEVEL_EN
      total++;
      if (tx_level !== 5'd8) begin
        bad++;
        $display("FAIL b2b_level n=%0d got=%0d exp=8", n, tx_level);
      end
`endif
    end
    bus.tx_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (bus.ser_tx_valid !== 1'b1 || bus.ser_tx_data !== q[k]) begin
        bad++;
        $display("FAIL b2b_drain k=%0d got=%b/%h exp=1/%h", k, bus.ser_tx_valid, bus.ser_tx_data, q[k]);
      end
      tick();
    end
    bus.ser_tx_ready = 1'b0;
    total++;
    if (bus.ser_tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_count got=%b exp=0 after 8 pops", bus.ser_tx_valid);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_w;
    bus.ser_tx_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.tx_data = 8'(8'h40 + k);
      bus.tx_valid = 1'b1;
      tick();
    end
    bus.tx_data = 8'hEE;
    total++;
    if (bus.tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got=%b exp=0", bus.tx_ready);
    end
    tick(); tick();
    total++;
    if (bus.tx_ready !== 1'b0 || bus.ser_tx_data !== 8'h40) begin
      bad++;
      $display("FAIL full_hold got=%b/%h exp=0/40", bus.tx_ready, bus.ser_tx_data);
    end
    bus.ser_tx_ready = 1'b1;
    tick();
    bus.ser_tx_ready = 1'b0;
    total++;
    if (bus.tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_pop_ready got=%b exp=1", bus.tx_ready);
    end
    tick();
    bus.tx_valid = 1'b0;
    total++;
    if (bus.tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_refill got=%b exp=0", bus.tx_ready);
    end
    bus.ser_tx_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      exp_w = (k == 16) ? 8'hEE : 8'(8'h40 + k);
      total++;
      if (bus.ser_tx_valid !== 1'b1 || bus.ser_tx_data !== exp_w) begin
        bad++;
        $display("FAIL full_drain k=%0d got=%b/%h exp=1/%h", k, bus.ser_tx_valid, bus.ser_tx_data, exp_w);
      end
      tick();
    end
    bus.ser_tx_ready = 1'b0;
    total++;
    if (bus.ser_tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_drain_end got=%b exp=0", bus.ser_tx_valid);
    end
  endtask

  task automatic test_async_reset();
    bus.ser_tx_ready = 1'b0;
    bus.rx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.ser_rx_data = 8'(8'h21 + k); bus.ser_rx_valid = 1'b1;
      bus.tx_data = 8'(8'h31 + k);     bus.tx_valid = 1'b1;
      tick();
    end
    bus.ser_rx_valid = 1'b0;
    bus.tx_valid = 1'b0;
    total++;
    if (bus.rx_data !== 8'h21 || bus.ser_tx_data !== 8'h31) begin
      bad++;
      $display("FAIL arst_queued got=%h/%h exp=21/31", bus.rx_data, bus.ser_tx_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.ser_rx_ready, bus.tx_ready, bus.ser_rts, bus.rx_valid, bus.ser_tx_valid} !== 5'b0) begin
      bad++;
      $display("FAIL arst_ctrl got=%b exp=00000",
               {bus.ser_rx_ready, bus.tx_ready, bus.ser_rts, bus.rx_valid, bus.ser_tx_valid});
    end
    total++;
    if (bus.rx_data !== 8'h00 || bus.ser_tx_data !== 8'h00) begin
      bad++;
      $display("FAIL arst_data got=%h/%h exp=00/00", bus.rx_data, bus.ser_tx_data);
    end
`ifdef SERIAL_BUFFERED_PORT_LEVEL_EN
    total++;
    if (rx_level !== 5'd0 || tx_level !== 5'd0) begin
      bad++;
      $display("FAIL arst_level got=%0d/%0d exp=0/0", rx_level, tx_level);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick(); tick();
    total++;
    if (bus.rx_valid !== 1'b0 || bus.ser_tx_valid !== 1'b0 || bus.ser_rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL arst_restart got=%b/%b/%b exp=0/0/1", bus.rx_valid, bus.ser_tx_valid, bus.ser_rx_ready);
    end
    bus.ser_rx_data = 8'h5A; bus.ser_rx_valid = 1'b1;
    bus.tx_data = 8'h6B;     bus.tx_valid = 1'b1;
    tick();
    bus.ser_rx_valid = 1'b0;
    bus.tx_valid = 1'b0;
    total++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A || bus.ser_tx_valid !== 1'b1 || bus.ser_tx_data !== 8'h6B) begin
      bad++;
      $display("FAIL arst_fresh got=%b/%h %b/%h exp=1/5a 1/6b", bus.rx_valid, bus.rx_data,
               bus.ser_tx_valid, bus.ser_tx_data);
    end
    bus.rx_ready = 1'b1;
    bus.ser_tx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    bus.ser_tx_ready = 1'b0;
    total++;
    if (bus.rx_valid !== 1'b0 || bus.ser_tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL arst_no_stale got=%b/%b exp=0/0", bus.rx_valid, bus.ser_tx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_rx_fill();
    test_tx_throughput();
    test_back_to_back();
    test_full_pop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
